// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the data-memory access unit.
//   - mDS size codes (3 is reserved and decoded as word)
//   - FSM state type
//   - byte-enable constants for word and half-word lanes
package mau_pkg;

    localparam logic [1:0] MDS_WORD = 2'd0;
    localparam logic [1:0] MDS_HALF = 2'd1;
    localparam logic [1:0] MDS_BYTE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

endpackage

// File: rtl/mau_lane.sv
// mau_lane: combinational lane steering for mem_access_unit.
//   size, ext, off : access size code, load extension (1 = zero), byte offset addr[1:0]
//   wdata          : store data; wdata_rep is the lane-replicated copy for the bus
//   rdata_in       : bus read word; rdata_ext is the extracted, extended load result
//   be             : little-endian byte enables
//   misaligned     : word with off != 0 or half with off[0] != 0
// Macro MAU_ALIGN_CHECK_EN: when undefined, misaligned is tied to 0 and the low
// offset bits that do not select a lane are simply ignored.
module mau_lane
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        ext,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata_in[{off, 3'b000} +: 8];
    assign sel_half = off[1] ? rdata_in[31:16] : rdata_in[15:0];

    always_comb begin
        be         = BE_WORD;
        wdata_rep  = wdata;
        rdata_ext  = rdata_in;
        case (size)
            MDS_BYTE: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = ext ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            MDS_HALF: begin
                be        = off[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = ext ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            default: ; // word and reserved code: full-width pass-through
        endcase
    end

`ifdef MAU_ALIGN_CHECK_EN
    always_comb begin
        case (size)
            MDS_BYTE: misaligned = 1'b0;
            MDS_HALF: misaligned = off[0];
            default:  misaligned = (off != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns memr/memw loads and stores into one word-aligned bus
// transaction, stalls the pipeline until completion and returns extended load data.
//   clk, rst_n          : clock, synchronous active-low reset
//   memr, memw          : load / store request (write wins if both)
//   mDS, mBE            : access size, load extension (1 = zero-extend)
//   addr, wdata         : byte address, store data
//   rdata, addr_err,
//   bus_err             : results, valid only in DONE
//   stall               : holds the pipeline
//   bus_*               : request/response bus, fields held stable while bus_req
// Parameter TIMEOUT: REQ cycles without bus_ack before abort (0 = never).
// Macro MAU_ALIGN_CHECK_EN: enables misalignment detection (see mau_lane).
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memr,
    input  logic        memw,
    input  logic [1:0]  mDS,
    input  logic        mBE,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

    mau_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        ext_q, ext_d;
    logic        we_q, we_d;
    logic [31:0] baddr_q, baddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;

    logic [1:0]  lane_size, lane_off;
    logic        lane_ext;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rdata;
    logic        lane_misaligned;
    logic        timeout_hit;

    // The lane block serves the live request in IDLE and the latched one in REQ.
    assign lane_size = (state_q == IDLE) ? mDS       : size_q;
    assign lane_ext  = (state_q == IDLE) ? mBE       : ext_q;
    assign lane_off  = (state_q == IDLE) ? addr[1:0] : off_q;

    mau_lane u_lane (
        .size       (lane_size),
        .ext        (lane_ext),
        .off        (lane_off),
        .wdata      (wdata),
        .rdata_in   (bus_rdata),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (lane_rdata),
        .misaligned (lane_misaligned)
    );

    // cnt_q counts completed wait cycles; this cycle is number cnt_q + 1.
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt_q} + 9'd1) == TimeoutLim);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        off_d    = off_q;
        ext_d    = ext_q;
        we_d     = we_q;
        baddr_d  = baddr_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        rdata_d  = 32'h0;
        aerr_d   = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (memr || memw) begin
                    size_d   = mDS;
                    off_d    = addr[1:0];
                    ext_d    = mBE;
                    we_d     = memw;
                    baddr_d  = {addr[31:2], 2'b00};
                    be_d     = lane_be;
                    bwdata_d = lane_wdata;
                    cnt_d    = 8'd0;
                    if (lane_misaligned) begin
                        aerr_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    rdata_d = we_q ? 32'h0 : lane_rdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    berr_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            size_q   <= MDS_WORD;
            off_q    <= 2'b00;
            ext_q    <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= 32'h0;
            be_q     <= 4'h0;
            bwdata_q <= 32'h0;
            rdata_q  <= 32'h0;
            aerr_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            off_q    <= off_d;
            ext_q    <= ext_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            rdata_q  <= rdata_d;
            aerr_q   <= aerr_d;
            berr_q   <= berr_d;
        end
    end

    assign stall = rst_n && (((state_q == IDLE) && (memr || memw)) || (state_q == REQ));
    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = baddr_q;
    assign bus_be    = be_q;
    assign bus_wdata = bwdata_q;
    assign rdata     = rdata_q;
    assign addr_err  = aerr_q;
    assign bus_err   = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memr, memw, mBE, bus_ack;
    logic [1:0]  mDS;
    logic [31:0] addr, wdata, bus_rdata;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        stall, addr_err, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memr      (memr),
        .memw      (memw),
        .mDS       (mDS),
        .mBE       (mBE),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    typedef struct {
        logic [63:0] name;
        logic        rd, wr;
        logic [1:0]  ds;
        logic        ext;
        logic [31:0] a, wd, brd;
        int          delay;     // wait cycles before ack; large = never
        logic [31:0] e_baddr;
        logic [3:0]  e_be;
        logic [31:0] e_bwd;
        logic        e_we;
        logic [31:0] e_rdata;
        int          e_stalls, e_reqs;
        logic        e_aerr, e_berr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input logic [63:0] vn, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", vn, field, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] name, input logic rd, input logic wr,
                                input logic [1:0] ds, input logic ext, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] brd, input int delay,
                                input logic [31:0] e_baddr, input logic [3:0] e_be,
                                input logic [31:0] e_bwd, input logic e_we,
                                input logic [31:0] e_rdata, input int e_stalls,
                                input int e_reqs, input logic e_aerr, input logic e_berr);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.ds = ds; v.ext = ext; v.a = a; v.wd = wd;
        v.brd = brd; v.delay = delay; v.e_baddr = e_baddr; v.e_be = e_be; v.e_bwd = e_bwd;
        v.e_we = e_we; v.e_rdata = e_rdata; v.e_stalls = e_stalls; v.e_reqs = e_reqs;
        v.e_aerr = e_aerr; v.e_berr = e_berr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int  stalls = 0;
        int  reqs   = 0;
        bit  done   = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                memr = v.rd; memw = v.wr; mDS = v.ds; mBE = v.ext;
                addr = v.a; wdata = v.wd; bus_rdata = v.brd; bus_ack = 1'b0;
            end
            #1;
            if (stall) stalls++;
            if (bus_req) begin
                chk(v.name, "bus_addr", bus_addr, v.e_baddr);
                chk(v.name, "bus_be", {28'h0, bus_be}, {28'h0, v.e_be});
                chk(v.name, "bus_wdata", bus_wdata, v.e_bwd);
                chk(v.name, "bus_we", {31'h0, bus_we}, {31'h0, v.e_we});
                bus_ack = (reqs == v.delay);
                reqs++;
            end else if (cyc > 0 && !stall) begin
                chk(v.name, "rdata", rdata, v.e_rdata);
                chk(v.name, "addr_err", {31'h0, addr_err}, {31'h0, v.e_aerr});
                chk(v.name, "bus_err", {31'h0, bus_err}, {31'h0, v.e_berr});
                chk(v.name, "stalls", stalls, v.e_stalls);
                chk(v.name, "req_cycles", reqs, v.e_reqs);
                memr = 1'b0; memw = 1'b0; bus_ack = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s.done: got no DONE within 40 cycles, expected completion", v.name);
            memr = 1'b0; memw = 1'b0; bus_ack = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = mk("SB", 0, 1, MDS_BYTE, 0, 32'h1003, 32'h000000A5, 32'hDEADBEEF, 0,
                      32'h1000, 4'b1000, 32'hA5A5A5A5, 1, 32'h0, 2, 1, 0, 0);
        vecs[1]  = mk("LH", 1, 0, MDS_HALF, 0, 32'h2002, 32'h12345678, 32'h80011234, 0,
                      32'h2000, 4'b1100, 32'h56785678, 0, 32'hFFFF8001, 2, 1, 0, 0);
        vecs[2]  = mk("LHU", 1, 0, MDS_HALF, 1, 32'h2002, 32'h12345678, 32'h80011234, 0,
                      32'h2000, 4'b1100, 32'h56785678, 0, 32'h00008001, 2, 1, 0, 0);
        vecs[3]  = mk("LB", 1, 0, MDS_BYTE, 0, 32'h2001, 32'h00000011, 32'h123480FF, 0,
                      32'h2000, 4'b0010, 32'h11111111, 0, 32'hFFFFFF80, 2, 1, 0, 0);
        vecs[4]  = mk("LBwait", 1, 0, MDS_BYTE, 0, 32'h2001, 32'h00000011, 32'h123480FF, 3,
                      32'h2000, 4'b0010, 32'h11111111, 0, 32'hFFFFFF80, 5, 4, 0, 0);
`ifdef MAU_ALIGN_CHECK_EN
        vecs[5]  = mk("LWmis", 1, 0, MDS_WORD, 0, 32'h3002, 32'h0, 32'hCAFEF00D, 0,
                      32'h3000, 4'b1111, 32'h0, 0, 32'h0, 1, 0, 1, 0);
        vecs[13] = mk("LHmis", 1, 0, MDS_HALF, 0, 32'h2003, 32'h0, 32'h80011234, 0,
                      32'h2000, 4'b1100, 32'h0, 0, 32'h0, 1, 0, 1, 0);
`else
        vecs[5]  = mk("LWmis", 1, 0, MDS_WORD, 0, 32'h3002, 32'h0, 32'hCAFEF00D, 0,
                      32'h3000, 4'b1111, 32'h0, 0, 32'hCAFEF00D, 2, 1, 0, 0);
        vecs[13] = mk("LHmis", 1, 0, MDS_HALF, 0, 32'h2003, 32'h0, 32'h80011234, 0,
                      32'h2000, 4'b1100, 32'h0, 0, 32'hFFFF8001, 2, 1, 0, 0);
`endif
        vecs[6]  = mk("TMO", 1, 0, MDS_WORD, 0, 32'h4000, 32'h0, 32'h12345678, 1000,
                      32'h4000, 4'b1111, 32'h0, 0, 32'h0, 9, 8, 0, 1);
        vecs[7]  = mk("LBU3", 1, 0, MDS_BYTE, 1, 32'h5003, 32'h0, 32'h9A000000, 0,
                      32'h5000, 4'b1000, 32'h0, 0, 32'h0000009A, 2, 1, 0, 0);
        vecs[8]  = mk("SH", 0, 1, MDS_HALF, 0, 32'h6000, 32'hFFFFBEEF, 32'h0, 0,
                      32'h6000, 4'b0011, 32'hBEEFBEEF, 1, 32'h0, 2, 1, 0, 0);
        vecs[9]  = mk("SWwait", 0, 1, MDS_WORD, 0, 32'h7000, 32'h01234567, 32'h0, 1,
                      32'h7000, 4'b1111, 32'h01234567, 1, 32'h0, 3, 2, 0, 0);
        vecs[10] = mk("BOTH", 1, 1, MDS_WORD, 0, 32'h8000, 32'hAABBCCDD, 32'h11111111, 0,
                      32'h8000, 4'b1111, 32'hAABBCCDD, 1, 32'h0, 2, 1, 0, 0);
        vecs[11] = mk("RSV", 1, 0, 2'd3, 0, 32'h9000, 32'h0, 32'h87654321, 0,
                      32'h9000, 4'b1111, 32'h0, 0, 32'h87654321, 2, 1, 0, 0);
        vecs[12] = mk("LHlo", 1, 0, MDS_HALF, 0, 32'h2000, 32'h0, 32'h80011234, 0,
                      32'h2000, 4'b0011, 32'h0, 0, 32'h00001234, 2, 1, 0, 0);

        // Reset: stall must stay low while rst_n is low even with a request pending.
        rst_n = 1'b0; memr = 1'b1; memw = 1'b0; mDS = MDS_WORD; mBE = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("RST", "stall", {31'h0, stall}, 32'h0);
        chk("RST", "bus_req", {31'h0, bus_req}, 32'h0);
        chk("RST", "bus_we", {31'h0, bus_we}, 32'h0);
        chk("RST", "flags", {30'h0, addr_err, bus_err}, 32'h0);
        chk("RST", "rdata", rdata, 32'h0);
        chk("RST", "bus_addr", bus_addr, 32'h0);
        chk("RST", "bus_be", {28'h0, bus_be}, 32'h0);
        chk("RST", "bus_wdata", bus_wdata, 32'h0);
        memr = 1'b0;
        rst_n = 1'b1;

        // Back-to-back table: each access starts in the IDLE cycle after the previous DONE.
        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset during the second REQ cycle: request withdrawn, no DONE, no error pulse.
        @(negedge clk);
        memr = 1'b1; mDS = MDS_WORD; addr = 32'hA000; bus_ack = 1'b0;
        @(negedge clk); #1;
        chk("RREQ", "req1", {31'h0, bus_req}, 32'h1);
        @(negedge clk); #1;
        chk("RREQ", "req2", {31'h0, bus_req}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("RREQ", "bus_req", {31'h0, bus_req}, 32'h0);
        chk("RREQ", "stall", {31'h0, stall}, 32'h0);
        chk("RREQ", "bus_err", {31'h0, bus_err}, 32'h0);
        chk("RREQ", "state", {30'h0, dut.state_q}, {30'h0, IDLE});
        memr = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;
        chk("RREQ", "post_err", {30'h0, addr_err, bus_err}, 32'h0);
        chk("RREQ", "post_stall", {31'h0, stall}, 32'h0);
        chk("RREQ", "post_state", {30'h0, dut.state_q}, {30'h0, IDLE});

        // The unit must be fully usable after the withdrawal.
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
